run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
//  Synthesizable replacement for the hand-timed start/halt bench sequence; programs are no longer released by fixed #ns delays.
//  It sequences NUM_PROGS programs through a TopLevel-style core:
//  - request a ROM load;
//  - wait a settle delay;
//  - pulse start;
//  - enforce a minimum run window;
//  - wait for halt or a timeout.
//  It reports one per-program result (cycle count, status) over a valid/ready port.
//  It sits between the program loader, the core's start/halt pins and a result sink (scoreboard or status registers).
// PARAMETERS
//  NUM_PROGS     19  number of programs sequenced per go; prog_idx runs 0..NUM_PROGS-1
//  SETTLE_CYC    10  cycles between load_done and start assertion (>=1)
//  PULSE_CYC     1   cycles start is held high (>=1)
//  MIN_RUN_CYC   55  cycles after start falls during which halt is ignored (>=0)
//  TIMEOUT_CYC   4096 max cycles after MIN_RUN window before timeout (>=1)
//  CNT_W         16  width of cycle counter / result count
// PORTS
//  CLK          in   1                       clock, rising edge
//  RST_n        in   1                       async active-low reset
//  go           in   1                       1-cycle request: run all programs; ignored unless state==IDLE
//  abort        in   1                       return to IDLE next cycle from any state; no result emitted
//  load_req     out  1                       request loader to load program prog_idx
//  load_done    in   1                       loader ack, 1-cycle pulse, valid only while load_req=1
//  prog_idx     out  $clog2(NUM_PROGS)       current program index
//  start        out  1                       to core; high PULSE_CYC cycles per program
//  halt         in   1                       from core; level, sampled only in WAIT_HALT
//  res_valid    out  1                       result available
//  res_ready    in   1                       sink accepts when res_valid&&res_ready
//  res_idx      out  $clog2(NUM_PROGS)       program index of result
//  res_cycles   out  CNT_W                   cycles from first start-high cycle to halt sample, saturating
//  res_timeout  out  1                       1 = halt never seen within TIMEOUT_CYC
//  busy         out  1                       state!=IDLE
//  all_done     out  1                       1-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; async assert, release synchronous to CLK.
//  FSM:
//  - IDLE -(go)-> LOAD: prog_idx=0, load_req=1.
//  - LOAD -(load_done)-> SETTLE: load_req drops the same edge; a load_done seen outside LOAD is ignored.
//  - SETTLE: count SETTLE_CYC cycles -> PULSE.
//  - PULSE: start=1 for PULSE_CYC cycles; the cycle counter clears to 1 on the first PULSE cycle -> MIN_RUN.
//  - MIN_RUN: count MIN_RUN_CYC cycles, halt ignored; MIN_RUN_CYC=0 skips this state -> WAIT_HALT.
//  - WAIT_HALT -> REPORT on halt=1 (timeout=0), or after TIMEOUT_CYC cycles without halt (timeout=1).
//    If halt and the final timeout cycle coincide, halt wins (timeout=0).
//  - REPORT: res_valid=1, outputs held stable until handshake.
//    On handshake, if prog_idx==NUM_PROGS-1: all_done pulse and -> IDLE.
//    Otherwise prog_idx+1 -> LOAD.
//  Cycle counter: increments every cycle from PULSE through WAIT_HALT inclusive; saturates at 2^CNT_W-1, no wrap.
//  Latency: the halt sample at edge N gives res_valid=1 after edge N; res_cycles excludes the REPORT cycle.
//  abort has priority over every transition: -> IDLE, start/load_req/res_valid drop next edge, all_done not pulsed.
//  go while busy: ignored.
//  RST_n low mid-run: immediate IDLE; start deasserts asynchronously.
//  halt high before MIN_RUN ends (a stale halt from the previous program) is not counted as completion.
// STRUCTURE
//  Package run_seq_pkg: typedef enum logic[2:0] {IDLE,LOAD,SETTLE,PULSE,MIN_RUN,WAIT_HALT,REPORT} run_state_t;
//  run_seq_pkg also holds a result struct {idx,cycles,timeout}.
//  One sub-module, sat_counter (CNT_W, clear/enable, saturating).
//  The FSM reuses a second sat_counter instance for the SETTLE/PULSE/MIN_RUN/TIMEOUT phase timer.
// TESTING
//  1) Sequence:
//     - Stimulus: NUM_PROGS=2, SETTLE=10, PULSE=1, MIN_RUN=55. go; loader acks after 3 cycles; halt 20 cycles after MIN_RUN.
//     - Response: start pulse is 1 cycle; res_cycles=1+55+20=76 for both programs; idx 0 then 1; all_done once.
//  2) Timeout:
//     - Stimulus: TIMEOUT_CYC=8, halt never asserts.
//     - Response: res_timeout=1, res_cycles=1+MIN_RUN+8, next program still loads.
//  3) Stale halt / boundary:
//     - Stimulus: halt held high from reset.
//     - Response: no completion before MIN_RUN ends; completion exactly on the first WAIT_HALT cycle.
//     - Stimulus: halt on the same cycle as the last timeout count.
//     - Response: timeout=0.
//  4) Backpressure:
//     - Stimulus: res_ready low 5 cycles.
//     - Response: res_* stable, no new load_req until the handshake; go pulsed mid-run is ignored.
//  5) Abort/reset:
//     - Stimulus: abort in WAIT_HALT.
//     - Response: IDLE next cycle, no res_valid.
//     - Stimulus: RST_n low in PULSE.
//     - Response: start=0 immediately; a fresh go restarts at prog_idx=0.
//  6) Saturation:
//     - Stimulus: CNT_W=4, halt at cycle 30.
//     - Response: res_cycles=15.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types for the program run sequencer: FSM states and the per-program result record.
// No logic here; the result record is sized generously so any instance's fields fit in it.
// Consumers narrow idx/cycles to their own widths.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        PULSE,
        MIN_RUN,
        WAIT_HALT,
        REPORT
    } run_state_t;

    localparam int RES_IDX_W = 8;
    localparam int RES_CNT_W = 32;

    typedef struct packed {
        logic [RES_IDX_W-1:0] idx;
        logic [RES_CNT_W-1:0] cycles;
        logic                 timeout;
    } run_result_t;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
// Latency: count visible the cycle after the clr/inc edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear has priority; increment stops at the all-ones ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Sequences NUM_PROGS programs through load -> settle -> start pulse -> min run -> halt/timeout.
// Latency: halt sampled at edge N gives res_valid after edge N; load_req follows a handshake by one edge.
// Backpressure: REPORT holds res_* stable until res_ready; no next load is requested before then.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter  int NUM_PROGS   = 19,
    parameter  int SETTLE_CYC  = 10,
    parameter  int PULSE_CYC   = 1,
    parameter  int MIN_RUN_CYC = 55,
    parameter  int TIMEOUT_CYC = 4096,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = clog2_min1(NUM_PROGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    output logic             load_req,
    input  logic             load_done,
    output logic [IDX_W-1:0] prog_idx,
    output logic             start,
    input  logic             halt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic             busy,
    output logic             all_done
);

    // Phase timer only has to reach the longest phase length minus one.
    localparam int M1    = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int M2    = (MIN_RUN_CYC > TIMEOUT_CYC) ? MIN_RUN_CYC : TIMEOUT_CYC;
    localparam int TMR_W = clog2_min1((M1 > M2) ? M1 : M2);

    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] MIN_RUN_LAST = TMR_W'((MIN_RUN_CYC > 0) ? MIN_RUN_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_PROGS - 1);

    run_state_t       state;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cyc;
    logic             settle_end;
    logic             pulse_end;
    logic             minrun_end;
    logic             wait_tmo;
    logic             in_phase;
    logic             phase_end;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             cyc_clr;
    logic             cyc_inc;

    // Phase-end decode; the timer reads k-1 during the k-th cycle of a timed phase.
    always_comb begin
        settle_end = (state == SETTLE)    && (tmr == SETTLE_LAST);
        pulse_end  = (state == PULSE)     && (tmr == PULSE_LAST);
        minrun_end = (state == MIN_RUN)   && (tmr == MIN_RUN_LAST);
        wait_tmo   = (state == WAIT_HALT) && (tmr == TIMEOUT_LAST);
        in_phase   = state inside {SETTLE, PULSE, MIN_RUN, WAIT_HALT};
        phase_end  = settle_end || pulse_end || minrun_end ||
                     ((state == WAIT_HALT) && (halt || wait_tmo));
        tmr_clr    = abort || !in_phase || phase_end;
        tmr_inc    = !tmr_clr;
        // Run counter loads 1 on entry to PULSE so it reads k during the k-th run cycle.
        cyc_clr    = settle_end;
        cyc_inc    = settle_end || (state inside {PULSE, MIN_RUN, WAIT_HALT});
    end

    sat_counter #(.W(TMR_W)) u_phase_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .cnt   (tmr)
    );

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cyc_clr),
        .inc   (cyc_inc),
        .cnt   (cyc)
    );

    // Sequencer FSM with registered handshake/control outputs; abort overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prog_idx    <= '0;
            load_req    <= 1'b0;
            start       <= 1'b0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            all_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                load_req  <= 1'b0;
                start     <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            state    <= LOAD;
                            prog_idx <= '0;
                            load_req <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (load_done) begin
                            state    <= SETTLE;
                            load_req <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (settle_end) begin
                            state <= PULSE;
                            start <= 1'b1;
                        end
                    end
                    PULSE: begin
                        if (pulse_end) begin
                            start <= 1'b0;
                            state <= (MIN_RUN_CYC > 0) ? MIN_RUN : WAIT_HALT;
                        end
                    end
                    MIN_RUN: begin
                        if (minrun_end) begin
                            state <= WAIT_HALT;
                        end
                    end
                    WAIT_HALT: begin
                        // Halt on the final timeout cycle still counts as a completion.
                        if (halt || wait_tmo) begin
                            state       <= REPORT;
                            res_valid   <= 1'b1;
                            res_idx     <= prog_idx;
                            res_cycles  <= cyc;
                            res_timeout <= !halt;
                        end
                    end
                    REPORT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (prog_idx == LAST_IDX) begin
                                state    <= IDLE;
                                all_done <= 1'b1;
                            end else begin
                                prog_idx <= prog_idx + IDX_W'(1);
                                load_req <= 1'b1;
                                state    <= LOAD;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances (baseline, short timeout, narrow counter).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the sink withholds res_ready for a few cycles on selected results.
module tb_run_sequencer;
    import run_seq_pkg::*;

    localparam int ND = 3;
    localparam int P_SETTLE [ND] = '{10, 10, 2};
    localparam int P_PULSE  [ND] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n       [ND];
    logic        go          [ND];
    logic        abort       [ND];
    logic        load_done   [ND];
    logic        halt        [ND];
    logic        res_ready   [ND];
    logic        load_req    [ND];
    logic        start       [ND];
    logic        res_valid   [ND];
    logic        res_timeout [ND];
    logic        busy        [ND];
    logic        all_done    [ND];
    logic [0:0]  prog_idx    [ND];
    logic [0:0]  res_idx     [ND];
    logic [15:0] res_cycles  [ND];
    logic [3:0]  res_cycles_c;

    int          n_tests;
    int          n_fail;
    run_result_t exp_q [$];

    assign res_cycles[2] = {12'd0, res_cycles_c};

    always #5 clk = ~clk;

    // Baseline: two programs, long timeout.
    run_sequencer #(.NUM_PROGS(2), .SETTLE_CYC(10), .PULSE_CYC(1), .MIN_RUN_CYC(55),
                    .TIMEOUT_CYC(4096), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]), .go(go[0]), .abort(abort[0]),
        .load_req(load_req[0]), .load_done(load_done[0]), .prog_idx(prog_idx[0]),
        .start(start[0]), .halt(halt[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_idx(res_idx[0]), .res_cycles(res_cycles[0]), .res_timeout(res_timeout[0]),
        .busy(busy[0]), .all_done(all_done[0]));

    // Short timeout window.
    run_sequencer #(.NUM_PROGS(2), .SETTLE_CYC(10), .PULSE_CYC(1), .MIN_RUN_CYC(55),
                    .TIMEOUT_CYC(8), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]), .go(go[1]), .abort(abort[1]),
        .load_req(load_req[1]), .load_done(load_done[1]), .prog_idx(prog_idx[1]),
        .start(start[1]), .halt(halt[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_idx(res_idx[1]), .res_cycles(res_cycles[1]), .res_timeout(res_timeout[1]),
        .busy(busy[1]), .all_done(all_done[1]));

    // Narrow counter, two-cycle pulse, no minimum run window.
    run_sequencer #(.NUM_PROGS(2), .SETTLE_CYC(2), .PULSE_CYC(2), .MIN_RUN_CYC(0),
                    .TIMEOUT_CYC(64), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n[2]), .go(go[2]), .abort(abort[2]),
        .load_req(load_req[2]), .load_done(load_done[2]), .prog_idx(prog_idx[2]),
        .start(start[2]), .halt(halt[2]), .res_valid(res_valid[2]), .res_ready(res_ready[2]),
        .res_idx(res_idx[2]), .res_cycles(res_cycles_c), .res_timeout(res_timeout[2]),
        .busy(busy[2]), .all_done(all_done[2]));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    task automatic pulse_go(input int d);
        go[d] = 1'b1;
        tick();
        go[d] = 1'b0;
    endtask

    // Loader acks three cycles into load_req, then the settle gap up to start is measured.
    task automatic start_prog(input int d, input int idx);
        int c;
        c = 0;
        while (!load_req[d] && c < 50) begin
            tick();
            c++;
        end
        chk(d, "load_req", load_req[d], 1);
        chk(d, "prog_idx", prog_idx[d], idx);
        chk(d, "busy", busy[d], 1);
        tick();
        tick();
        load_done[d] = 1'b1;
        tick();
        load_done[d] = 1'b0;
        chk(d, "load_drop", load_req[d], 0);
        c = 1;
        while (!start[d] && c < 100) begin
            tick();
            c++;
        end
        chk(d, "settle", c, P_SETTLE[d] + 1);
    endtask

    // c is the run cycle index (1 = first start-high cycle); halt rises once c reaches halt_at.
    task automatic finish_prog(input int d, input int halt_at, input int k_exp, input bit drop);
        int c;
        int pw;
        c  = 1;
        pw = 0;
        for (int i = 0; i < 300; i++) begin
            if (res_valid[d]) break;
            if (start[d]) pw++;
            if (halt_at != 0 && c >= halt_at) halt[d] = 1'b1;
            tick();
            c++;
        end
        chk(d, "res_latency", c, k_exp + 1);
        chk(d, "start_width", pw, P_PULSE[d]);
        if (drop) halt[d] = 1'b0;
    endtask

    // Holds res_ready low nwait cycles (with a stray go), then pops the scoreboard on handshake.
    task automatic drain(input int d, input int nwait, input bit last);
        run_result_t e;
        e = '0;
        chk(d, "sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        for (int i = 0; i < nwait; i++) begin
            chk(d, "hold_valid", res_valid[d], 1);
            chk(d, "hold_cycles", res_cycles[d], e.cycles);
            chk(d, "hold_no_load", load_req[d], 0);
            go[d] = (i == 1);
            tick();
        end
        go[d] = 1'b0;
        if (nwait > 0) chk(d, "go_ignored_idx", prog_idx[d], e.idx);
        res_ready[d] = 1'b1;
        chk(d, "res_valid", res_valid[d], 1);
        chk(d, "res_idx", res_idx[d], e.idx);
        chk(d, "res_cycles", res_cycles[d], e.cycles);
        chk(d, "res_timeout", res_timeout[d], e.timeout);
        tick();
        res_ready[d] = 1'b0;
        chk(d, "valid_drop", res_valid[d], 0);
        if (last) begin
            chk(d, "all_done", all_done[d], 1);
            chk(d, "idle_busy", busy[d], 0);
            tick();
            chk(d, "all_done_pulse", all_done[d], 0);
        end else begin
            chk(d, "no_all_done", all_done[d], 0);
            chk(d, "next_load", load_req[d], 1);
            chk(d, "next_idx", prog_idx[d], 32'(e.idx) + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < ND; d++) begin
            rst_n[d]     = 1'b0;
            go[d]        = 1'b0;
            abort[d]     = 1'b0;
            load_done[d] = 1'b0;
            halt[d]      = 1'b0;
            res_ready[d] = 1'b0;
        end
        repeat (3) tick();
        for (int d = 0; d < ND; d++) begin
            chk(d, "reset_outputs", {load_req[d], start[d], res_valid[d], busy[d], all_done[d],
                                     prog_idx[d], res_idx[d], res_timeout[d], res_cycles[d]}, 0);
            rst_n[d] = 1'b1;
        end
        tick();

        // Two-program sequence, halt 20 cycles after the min-run window, backpressure on result 0.
        pulse_go(0);
        start_prog(0, 0);
        exp_q.push_back('{idx: 8'd0, cycles: 32'd76, timeout: 1'b0});
        finish_prog(0, 76, 76, 1'b1);
        drain(0, 5, 1'b0);
        start_prog(0, 1);
        exp_q.push_back('{idx: 8'd1, cycles: 32'd76, timeout: 1'b0});
        finish_prog(0, 76, 76, 1'b1);
        drain(0, 0, 1'b1);

        // Stale halt held high: completion lands on the first WAIT_HALT cycle (1+55+1).
        halt[0] = 1'b1;
        tick();
        pulse_go(0);
        start_prog(0, 0);
        exp_q.push_back('{idx: 8'd0, cycles: 32'd57, timeout: 1'b0});
        finish_prog(0, 1, 57, 1'b0);
        drain(0, 0, 1'b0);
        start_prog(0, 1);
        exp_q.push_back('{idx: 8'd1, cycles: 32'd57, timeout: 1'b0});
        finish_prog(0, 1, 57, 1'b1);
        drain(0, 0, 1'b1);

        // Timeout after 8 waiting cycles, then halt coinciding with the last timeout cycle.
        pulse_go(1);
        start_prog(1, 0);
        exp_q.push_back('{idx: 8'd0, cycles: 32'd64, timeout: 1'b1});
        finish_prog(1, 0, 64, 1'b1);
        drain(1, 2, 1'b0);
        start_prog(1, 1);
        exp_q.push_back('{idx: 8'd1, cycles: 32'd64, timeout: 1'b0});
        finish_prog(1, 64, 64, 1'b1);
        drain(1, 0, 1'b1);

        // Abort while waiting for halt: idle next cycle, no result afterwards.
        pulse_go(0);
        start_prog(0, 0);
        for (int i = 1; i < 60; i++) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk(0, "abort_busy", busy[0], 0);
        chk(0, "abort_ctrl", {start[0], load_req[0], res_valid[0], all_done[0]}, 0);
        halt[0] = 1'b1;
        repeat (3) tick();
        chk(0, "abort_no_result", {res_valid[0], busy[0], all_done[0]}, 0);
        halt[0] = 1'b0;
        tick();

        // Reset asserted during program 1's start pulse, then a fresh go restarts at index 0.
        pulse_go(0);
        start_prog(0, 0);
        exp_q.push_back('{idx: 8'd0, cycles: 32'd70, timeout: 1'b0});
        finish_prog(0, 70, 70, 1'b1);
        drain(0, 0, 1'b0);
        start_prog(0, 1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk(0, "rst_start_async", start[0], 0);
        chk(0, "rst_busy", busy[0], 0);
        chk(0, "rst_idx", prog_idx[0], 0);
        tick();
        rst_n[0] = 1'b1;
        tick();
        pulse_go(0);
        start_prog(0, 0);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk(0, "restart_abort_busy", busy[0], 0);

        // Narrow counter saturates at 15; stale halt during the pulse completes on run cycle 3.
        pulse_go(2);
        start_prog(2, 0);
        exp_q.push_back('{idx: 8'd0, cycles: 32'd15, timeout: 1'b0});
        finish_prog(2, 30, 30, 1'b0);
        drain(2, 0, 1'b0);
        start_prog(2, 1);
        exp_q.push_back('{idx: 8'd1, cycles: 32'd3, timeout: 1'b0});
        finish_prog(2, 1, 3, 1'b1);
        drain(2, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
